// File: rtl/vm1_vcram_ctl_if.sv
// vm1_vcram_ctl_if -- bundle of every signal between the VM1 register-file
// port-B controller and its surroundings except clock and reset.
//
// Groups:
//   control   : init_start (in), busy (out), state_dbg (out, FSM state)
//   requester : rN_req / rN_we / rN_addr / rN_wdata (in),
//               rN_ack / rN_rvalid (out), rdata (out), N = 0, 1
//   snoop     : a_wren / a_addr (in), port-A write activity
//   RAM B     : ram_addr_b / ram_data_b / ram_wren_b (out), ram_q_b (in)
//
// Handshake: a requester raises rN_req with we/addr/wdata stable and holds
// all of them until it sees rN_ack high at a rising edge. That edge is the
// access. For a read, rN_rvalid is high in the following cycle and rdata
// carries the word. An ack is never registered: it is a combinational grant.
//
// slave  : the controller's view.
// master : the environment's view (requesters, RAM model, snoop source).
interface vm1_vcram_ctl_if #(
  parameter int AW = 6,
  parameter int DW = 16
);
  logic          init_start;
  logic          busy;
  logic [0:0]    state_dbg;
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_ack;
  logic          r0_rvalid;
  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_ack;
  logic          r1_rvalid;
  logic [DW-1:0] rdata;
  logic          a_wren;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_data_b;
  logic          ram_wren_b;
  logic [DW-1:0] ram_q_b;

  modport slave (
    input  init_start, r0_req, r0_we, r0_addr, r0_wdata,
           r1_req, r1_we, r1_addr, r1_wdata, a_wren, a_addr, ram_q_b,
    output busy, state_dbg, r0_ack, r0_rvalid, r1_ack, r1_rvalid, rdata,
           ram_addr_b, ram_data_b, ram_wren_b
  );

  modport master (
    output init_start, r0_req, r0_we, r0_addr, r0_wdata,
           r1_req, r1_we, r1_addr, r1_wdata, a_wren, a_addr, ram_q_b,
    input  busy, state_dbg, r0_ack, r0_rvalid, r1_ack, r1_rvalid, rdata,
           ram_addr_b, ram_data_b, ram_wren_b
  );
endinterface

// File: rtl/vm1_vcram_ctl.sv
// vm1_vcram_ctl -- port-B controller for the VM1 64x16 dual-port register
// file. After reset (or an init_start pulse while running) it writes
// INIT_DATA to every word, one word per cycle. Afterwards it shares port B
// between r0 (microcode writeback) and r1 (console/debug) with a
// round-robin arbiter, holding back any write that would hit the same
// address port A is writing in that cycle.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : vm1_vcram_ctl_if.slave (requesters, snoop, RAM port B, status)
module vm1_vcram_ctl #(
  parameter int            AW        = 6,
  parameter int            DW        = 16,
  parameter logic [DW-1:0] INIT_DATA = '0
) (
  input  logic             clock,
  input  logic             reset,
  vm1_vcram_ctl_if.slave   bus
);
  localparam logic [0:0]    ST_INIT   = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  logic [0:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_ptr;      // side that wins a tie: 0 = r0, 1 = r1
  logic          r_rvalid0;
  logic          r_rvalid1;

  logic w_run;
  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;

  // Reset gates the grant path combinationally so no ack or write strobe
  // can appear while reset is high, even mid-cycle.
  assign w_run = (r_state == ST_RUN) && !reset;

  // A write to the address port A is writing this cycle is held back.
  // Reads stay eligible: the registered RAM returns the pre-write word.
  assign w_elig0 = bus.r0_req &&
                   !(bus.r0_we && bus.a_wren && (bus.r0_addr == bus.a_addr));
  assign w_elig1 = bus.r1_req &&
                   !(bus.r1_we && bus.a_wren && (bus.r1_addr == bus.a_addr));

  assign w_gnt0 = w_run && w_elig0 && (!w_elig1 || !r_ptr);
  assign w_gnt1 = w_run && w_elig1 && (!w_elig0 ||  r_ptr);

  always_comb begin
    bus.ram_wren_b = 1'b0;
    bus.ram_addr_b = bus.r0_addr;
    bus.ram_data_b = bus.r0_wdata;
    if (r_state == ST_INIT) begin
      bus.ram_wren_b = !reset;
      bus.ram_addr_b = r_cnt;
      bus.ram_data_b = INIT_DATA;
    end else if (w_gnt1) begin
      bus.ram_wren_b = bus.r1_we;
      bus.ram_addr_b = bus.r1_addr;
      bus.ram_data_b = bus.r1_wdata;
    end else if (w_gnt0) begin
      bus.ram_wren_b = bus.r0_we;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_ptr     <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      // Registered so an rvalid due from the last RUN cycle still arrives
      // in the first INIT cycle after init_start.
      r_rvalid0 <= w_gnt0 && !bus.r0_we;
      r_rvalid1 <= w_gnt1 && !bus.r1_we;
      if (r_state == ST_INIT) begin
        // Counter wraps to 0 on the edge that writes the last address.
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          r_state <= ST_RUN;
        end
      end else begin
        if (w_gnt0) begin
          r_ptr <= 1'b1;
        end else if (w_gnt1) begin
          r_ptr <= 1'b0;
        end
        if (bus.init_start) begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      end
    end
  end

  assign bus.busy      = reset || (r_state == ST_INIT);
  assign bus.state_dbg = r_state;
  assign bus.r0_ack    = w_gnt0;
  assign bus.r1_ack    = w_gnt1;
  assign bus.r0_rvalid = r_rvalid0;
  assign bus.r1_rvalid = r_rvalid1;
  assign bus.rdata     = bus.ram_q_b;
endmodule

// File: tb/tb_vm1_vcram_ctl.sv
// tb_vm1_vcram_ctl -- directed bench for vm1_vcram_ctl (AW=6, DW=16,
// INIT_DATA=16'hA5A5). A small registered RAM model sits on port B.
// Arbitration is exercised by a table of per-cycle vectors with
// hand-computed acks, strobes and read returns; clear, init_start and reset
// corner cases are hand-written sequences.
module tb_vm1_vcram_ctl;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam logic [DW-1:0] INIT_VAL = 16'hA5A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vm1_vcram_ctl_if #(.AW(AW), .DW(DW)) vif ();

  vm1_vcram_ctl #(.AW(AW), .DW(DW), .INIT_DATA(INIT_VAL)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (vif)
  );

  // Registered RAM, port B only: read returns the word before any write
  // at the same edge.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (vif.ram_wren_b) mem[vif.ram_addr_b] <= vif.ram_data_b;
    vif.ram_q_b <= mem[vif.ram_addr_b];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic q0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic q1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic aw, input logic [AW-1:0] aa);
    vif.r0_req = q0; vif.r0_we = w0; vif.r0_addr = a0; vif.r0_wdata = d0;
    vif.r1_req = q1; vif.r1_we = w1; vif.r1_addr = a1; vif.r1_wdata = d1;
    vif.a_wren = aw; vif.a_addr = aa;
  endtask

  // Called in the low phase of the first clear cycle; checks all 64 clear
  // writes and leaves the bench in the low phase of the first RUN cycle.
  task automatic run_clear(input string tag, input int pulse_at);
    for (int i = 0; i < 64; i++) begin
      vif.init_start = (i == pulse_at);
      #1;
      chk($sformatf("%s busy[%0d]", tag, i), vif.busy, 1);
      chk($sformatf("%s wren[%0d]", tag, i), vif.ram_wren_b, 1);
      chk($sformatf("%s addr[%0d]", tag, i), vif.ram_addr_b, i);
      chk($sformatf("%s data[%0d]", tag, i), vif.ram_data_b, INIT_VAL);
      chk($sformatf("%s noack[%0d]", tag, i), {vif.r0_ack, vif.r1_ack}, 0);
      @(negedge clk);
    end
    vif.init_start = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic q0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic q1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic aw; logic [AW-1:0] aa;
    logic e_ack0, e_ack1, e_wren, e_rv0, e_rv1;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic q0, w0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic q1, w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic aw, input logic [AW-1:0] aa,
                              input logic ea0, ea1, ew, ev0, ev1,
                              input logic [DW-1:0] erd);
    vec_t v;
    v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.aw = aw; v.aa = aa;
    v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_wren = ew;
    v.e_rv0 = ev0; v.e_rv1 = ev1; v.e_rdata = erd;
    return v;
  endfunction

  initial begin
    //               r0: q w addr data        r1: q w addr data       snoop   ack0 ack1 wren rv0 rv1 rdata
    vecs[0]  = mk(1,1,6'd5, 16'h1234, 0,0,6'd0, 16'h0000, 0,6'd0,  1,0,1, 0,0, 16'h0000);
    vecs[1]  = mk(1,0,6'd5, 16'h0000, 0,0,6'd0, 16'h0000, 0,6'd0,  1,0,0, 0,0, 16'h0000);
    vecs[2]  = mk(1,0,6'd37,16'h0000, 0,0,6'd0, 16'h0000, 0,6'd0,  1,0,0, 1,0, 16'h1234);
    vecs[3]  = mk(0,0,6'd0, 16'h0000, 0,0,6'd0, 16'h0000, 0,6'd0,  0,0,0, 1,0, 16'hA5A5);
    vecs[4]  = mk(0,0,6'd0, 16'h0000, 1,1,6'd10,16'hBEEF, 0,6'd0,  0,1,1, 0,0, 16'h0000);
    // both continuously requesting: r0 read a10, r1 write a11
    vecs[5]  = mk(1,0,6'd10,16'h0000, 1,1,6'd11,16'h1111, 0,6'd0,  1,0,0, 0,0, 16'h0000);
    vecs[6]  = mk(1,0,6'd10,16'h0000, 1,1,6'd11,16'h1111, 0,6'd0,  0,1,1, 1,0, 16'hBEEF);
    vecs[7]  = mk(1,0,6'd10,16'h0000, 1,1,6'd11,16'h1111, 0,6'd0,  1,0,0, 0,0, 16'h0000);
    vecs[8]  = mk(1,0,6'd10,16'h0000, 1,1,6'd11,16'h1111, 0,6'd0,  0,1,1, 1,0, 16'hBEEF);
    vecs[9]  = mk(1,0,6'd10,16'h0000, 1,1,6'd11,16'h1111, 0,6'd0,  1,0,0, 0,0, 16'h0000);
    vecs[10] = mk(1,0,6'd10,16'h0000, 1,1,6'd11,16'h1111, 0,6'd0,  0,1,1, 1,0, 16'hBEEF);
    vecs[11] = mk(0,0,6'd0, 16'h0000, 0,0,6'd0, 16'h0000, 0,6'd0,  0,0,0, 0,0, 16'h0000);
    // port A writing a9 for 3 cycles: r1 write blocked, r0 read passes
    vecs[12] = mk(1,0,6'd9, 16'h0000, 1,1,6'd9, 16'h5555, 1,6'd9,  1,0,0, 0,0, 16'h0000);
    vecs[13] = mk(0,0,6'd0, 16'h0000, 1,1,6'd9, 16'h5555, 1,6'd9,  0,0,0, 1,0, 16'hA5A5);
    vecs[14] = mk(0,0,6'd0, 16'h0000, 1,1,6'd9, 16'h5555, 1,6'd9,  0,0,0, 0,0, 16'h0000);
    vecs[15] = mk(0,0,6'd0, 16'h0000, 1,1,6'd9, 16'h5555, 0,6'd9,  0,1,1, 0,0, 16'h0000);
    vecs[16] = mk(0,0,6'd0, 16'h0000, 1,0,6'd9, 16'h0000, 0,6'd0,  0,1,0, 0,0, 16'h0000);
    vecs[17] = mk(0,0,6'd0, 16'h0000, 0,0,6'd0, 16'h0000, 0,6'd0,  0,0,0, 0,1, 16'h5555);
    // port A writing a different address does not block
    vecs[18] = mk(0,0,6'd0, 16'h0000, 1,1,6'd12,16'h7777, 1,6'd13, 0,1,1, 0,0, 16'h0000);
    vecs[19] = mk(1,0,6'd63,16'h0000, 0,0,6'd0, 16'h0000, 0,6'd0,  1,0,0, 0,0, 16'h0000);
    vecs[20] = mk(0,0,6'd0, 16'h0000, 0,0,6'd0, 16'h0000, 0,6'd0,  0,0,0, 1,0, 16'hA5A5);
    vecs[21] = mk(1,1,6'd20,16'h2222, 1,0,6'd12,16'h0000, 1,6'd20, 0,1,0, 0,0, 16'h0000);
    vecs[22] = mk(0,0,6'd0, 16'h0000, 0,0,6'd0, 16'h0000, 0,6'd0,  0,0,0, 0,1, 16'h7777);
  end

  // ---------------- test sequence ----------------
  initial begin
    vif.init_start = 1'b0;
    // r0 write is pending through reset and the whole first clear
    drive(1, 1, 6'd5, 16'h1234, 0, 0, 6'd0, 16'h0, 0, 6'd0);
    @(negedge clk);
    #1;
    chk("reset busy",  vif.busy, 1);
    chk("reset wren",  vif.ram_wren_b, 0);
    chk("reset acks",  {vif.r0_ack, vif.r1_ack}, 0);
    chk("reset rvals", {vif.r0_rvalid, vif.r1_rvalid}, 0);
    chk("reset state", vif.state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    run_clear("clear0", -1);

    // table-driven RUN cycles
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].q0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].q1, vecs[i].w1, vecs[i].a1, vecs[i].d1,
            vecs[i].aw, vecs[i].aa);
      #1;
      chk($sformatf("v%0d busy", i), vif.busy, 0);
      chk($sformatf("v%0d ack0", i), vif.r0_ack, vecs[i].e_ack0);
      chk($sformatf("v%0d ack1", i), vif.r1_ack, vecs[i].e_ack1);
      chk($sformatf("v%0d wren", i), vif.ram_wren_b, vecs[i].e_wren);
      chk($sformatf("v%0d rv0", i), vif.r0_rvalid, vecs[i].e_rv0);
      chk($sformatf("v%0d rv1", i), vif.r1_rvalid, vecs[i].e_rv1);
      if (vecs[i].e_ack1)
        chk($sformatf("v%0d addr", i), vif.ram_addr_b, vecs[i].a1);
      else if (vecs[i].e_ack0)
        chk($sformatf("v%0d addr", i), vif.ram_addr_b, vecs[i].a0);
      if (vecs[i].e_rv0 || vecs[i].e_rv1) exp_q.push_back(vecs[i].e_rdata);
      if (exp_q.size() > 0)
        chk($sformatf("v%0d rdata", i), vif.rdata, exp_q.pop_front());
      @(negedge clk);
    end

    // init_start in RUN with an r0 read of a12 in the same cycle
    drive(1, 0, 6'd12, 16'h0, 0, 0, 6'd0, 16'h0, 0, 6'd0);
    vif.init_start = 1'b1;
    #1;
    chk("istart ack0", vif.r0_ack, 1);
    chk("istart busy", vif.busy, 0);
    @(negedge clk);
    vif.init_start = 1'b0;
    #1;
    chk("istart busy rise", vif.busy, 1);
    chk("istart state", vif.state_dbg, 0);
    chk("istart late rv0", vif.r0_rvalid, 1);
    chk("istart late rdata", vif.rdata, 16'h7777);
    // r0 keeps requesting a12 through the clear; init_start pulsed at 10
    run_clear("clear1", 10);
    #1;
    chk("clear1 busy fall", vif.busy, 0);
    chk("clear1 first ack", vif.r0_ack, 1);
    @(negedge clk);
    drive(0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 6'd0);
    #1;
    chk("clear1 rv0", vif.r0_rvalid, 1);
    chk("clear1 rdata", vif.rdata, INIT_VAL);
    @(negedge clk);

    // reset at clear counter 20
    vif.init_start = 1'b1;
    @(negedge clk);
    vif.init_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("part addr[%0d]", i), vif.ram_addr_b, i);
      @(negedge clk);
    end
    #1;
    chk("part addr20", vif.ram_addr_b, 20);
    chk("part wren20", vif.ram_wren_b, 1);
    rst = 1'b1;
    #1;
    chk("midinit rst wren", vif.ram_wren_b, 0);
    chk("midinit rst busy", vif.busy, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_clear("clear2", -1);
    #1;
    chk("clear2 busy fall", vif.busy, 0);

    // reset in RUN drops a pending rvalid
    drive(1, 0, 6'd5, 16'h0, 0, 0, 6'd0, 16'h0, 0, 6'd0);
    #1;
    chk("runrst ack0", vif.r0_ack, 1);
    @(negedge clk);
    drive(0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0, 0, 6'd0);
    #1;
    chk("runrst rv0 before", vif.r0_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("runrst rv0 dropped", vif.r0_rvalid, 0);
    chk("runrst wren", vif.ram_wren_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_clear("clear3", -1);
    #1;
    chk("clear3 busy fall", vif.busy, 0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
